// File: rtl/multicycle_controller.sv
// Sequencing FSM for the shared-memory multicycle RV32I-subset datapath.
// Latency: 3-5 cycles per instruction; FETCH/MEMREAD/MEMWRITE hold while mem_ready is low.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] immsrc,
    output logic       regwrite,
    output logic       illegal,
    output logic       instr_done
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_JALR,
        S_JALRPC,
        S_ILLEGAL
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        adrsrc     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        regwrite   = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                // ALU computes PC+4 in parallel with the instruction read.
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                // ALUOut still holds the target computed in DECODE.
                alusrca    = 2'b10;
                aluop      = 2'b01;
                pcwrite    = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = S_JALRPC;
            end
            S_JALRPC: begin
                // Redirect PC from rs1+imm while the ALU forms the link value OldPC+4.
                pcwrite = 1'b1;
                alusrca = 2'b01;
                alusrcb = 2'b10;
                state_d = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            pcwrite    = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle bench for multicycle_controller: per-state output vectors.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    localparam logic [1:0] IM_I = 2'b00;
    localparam logic [1:0] IM_S = 2'b01;
    localparam logic [1:0] IM_B = 2'b10;
    localparam logic [1:0] IM_J = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal, instr_done;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop, immsrc;
    logic [16:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .immsrc     (immsrc),
        .regwrite   (regwrite),
        .illegal    (illegal),
        .instr_done (instr_done)
    );

    // {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, aluop, immsrc, regwrite, illegal, instr_done}
    assign outs = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
                   aluop, immsrc, regwrite, illegal, instr_done};

    function automatic logic [16:0] mk(input logic pc, input logic adr, input logic mw,
                                       input logic ir, input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] ao,
                                       input logic [1:0] im, input logic rw, input logic il,
                                       input logic dn);
        return {pc, adr, mw, ir, rs, a, b, ao, im, rw, il, dn};
    endfunction

    // Expected outputs per state, hand-written from the state table.
    function automatic logic [16:0] e_fetch(input logic r, input logic [1:0] im);
        return mk(r, 1'b0, 1'b0, r, 2'b10, 2'b00, 2'b10, 2'b00, im, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_decode(input logic [1:0] im);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, im, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_memadr(input logic [1:0] im);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, im, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_memread(input logic [1:0] im);
        return mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_memwb(input logic [1:0] im);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, im, 1'b1, 1'b0, 1'b1);
    endfunction
    function automatic logic [16:0] e_memwrite(input logic r, input logic [1:0] im);
        return mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0, 1'b0, r);
    endfunction
    function automatic logic [16:0] e_execr(input logic [1:0] im);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, im, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_execi(input logic [1:0] im);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, im, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_aluwb(input logic [1:0] im);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b1, 1'b0, 1'b1);
    endfunction
    function automatic logic [16:0] e_beq(input logic z, input logic [1:0] im);
        return mk(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, im, 1'b0, 1'b0, 1'b1);
    endfunction
    function automatic logic [16:0] e_jal(input logic [1:0] im);
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, im, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_jalr(input logic [1:0] im);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, im, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_jalrpc(input logic [1:0] im);
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, im, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_illegal(input logic [1:0] im);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0, 1'b1, 1'b1);
    endfunction

    task automatic test_reset();
        rst = 1'b1; op = OP_R; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (outs !== e_fetch(1'b0, IM_I)) begin
            $display("FAIL reset_outputs: got %h want %h", outs, e_fetch(1'b0, IM_I)); errors++;
        end
        @(negedge clk); mem_ready = 1'b0; rst = 1'b0; #1;
        checks++;
        if (outs !== e_fetch(1'b0, IM_I)) begin
            $display("FAIL reset_release_stall: got %h want %h", outs, e_fetch(1'b0, IM_I)); errors++;
        end
    endtask

    task automatic test_rtype();
        logic [16:0] ev [4];
        logic [0:3]  mr;
        ev = '{e_fetch(1'b1, IM_I), e_decode(IM_I), e_execr(IM_I), e_aluwb(IM_I)};
        mr = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); op = OP_R; mem_ready = mr[i]; #1;
            checks++;
            if (outs !== ev[i]) begin
                $display("FAIL rtype cyc%0d: got %h want %h", i, outs, ev[i]); errors++;
            end
        end
    endtask

    task automatic test_itype_fetch_stall();
        logic [16:0] ev [5];
        logic [0:4]  mr;
        ev = '{e_fetch(1'b0, IM_I), e_fetch(1'b1, IM_I), e_decode(IM_I), e_execi(IM_I),
               e_aluwb(IM_I)};
        mr = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); op = OP_I; mem_ready = mr[i]; #1;
            checks++;
            if (outs !== ev[i]) begin
                $display("FAIL itype cyc%0d: got %h want %h", i, outs, ev[i]); errors++;
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [16:0] ev [7];
        logic [0:6]  mr;
        ev = '{e_fetch(1'b1, IM_I), e_decode(IM_I), e_memadr(IM_I), e_memread(IM_I),
               e_memread(IM_I), e_memread(IM_I), e_memwb(IM_I)};
        mr = 7'b1000010;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); op = OP_LW; mem_ready = mr[i]; #1;
            checks++;
            if (outs !== ev[i]) begin
                $display("FAIL lw cyc%0d: got %h want %h", i, outs, ev[i]); errors++;
            end
        end
    endtask

    task automatic test_sw_wait();
        logic [16:0] ev [5];
        logic [0:4]  mr;
        ev = '{e_fetch(1'b1, IM_S), e_decode(IM_S), e_memadr(IM_S), e_memwrite(1'b0, IM_S),
               e_memwrite(1'b1, IM_S)};
        mr = 5'b10001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); op = OP_SW; mem_ready = mr[i]; #1;
            checks++;
            if (outs !== ev[i]) begin
                $display("FAIL sw cyc%0d: got %h want %h", i, outs, ev[i]); errors++;
            end
        end
    endtask

    task automatic test_beq(input logic z);
        logic [16:0] ev [3];
        ev = '{e_fetch(1'b1, IM_B), e_decode(IM_B), e_beq(z, IM_B)};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); op = OP_BEQ; mem_ready = 1'b1; zero = (i == 2) ? z : ~z; #1;
            checks++;
            if (outs !== ev[i]) begin
                $display("FAIL beq_z%0d cyc%0d: got %h want %h", z, i, outs, ev[i]); errors++;
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal_jalr();
        logic [16:0] ej [4];
        logic [16:0] er [5];
        ej = '{e_fetch(1'b1, IM_J), e_decode(IM_J), e_jal(IM_J), e_aluwb(IM_J)};
        er = '{e_fetch(1'b1, IM_I), e_decode(IM_I), e_jalr(IM_I), e_jalrpc(IM_I), e_aluwb(IM_I)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); op = OP_JAL; mem_ready = 1'b1; #1;
            checks++;
            if (outs !== ej[i]) begin
                $display("FAIL jal cyc%0d: got %h want %h", i, outs, ej[i]); errors++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); op = OP_JALR; mem_ready = (i == 0); #1;
            checks++;
            if (outs !== er[i]) begin
                $display("FAIL jalr cyc%0d: got %h want %h", i, outs, er[i]); errors++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [16:0] ev [4];
        ev = '{e_fetch(1'b1, IM_I), e_decode(IM_I), e_illegal(IM_I), e_fetch(1'b1, IM_I)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); op = OP_BAD; mem_ready = 1'b1; #1;
            checks++;
            if (outs !== ev[i]) begin
                $display("FAIL illegal cyc%0d: got %h want %h", i, outs, ev[i]); errors++;
            end
        end
        // The trailing fetch above completed; finish that instruction as an R-type.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); op = OP_R; mem_ready = 1'b1; #1;
        end
    endtask

    task automatic test_reset_in_memwrite();
        logic [16:0] ev [4];
        ev = '{e_fetch(1'b1, IM_S), e_decode(IM_S), e_memadr(IM_S), e_memwrite(1'b0, IM_S)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); op = OP_SW; mem_ready = (i == 0); #1;
            checks++;
            if (outs !== ev[i]) begin
                $display("FAIL rst_sw cyc%0d: got %h want %h", i, outs, ev[i]); errors++;
            end
        end
        #2 rst = 1'b1; #1;
        checks++;
        if (memwrite !== 1'b0) begin
            $display("FAIL rst_memwrite_drop: got %b want 0", memwrite); errors++;
        end
        checks++;
        if (outs !== e_fetch(1'b0, IM_S)) begin
            $display("FAIL rst_abort_outputs: got %h want %h", outs, e_fetch(1'b0, IM_S)); errors++;
        end
        @(negedge clk); rst = 1'b0; op = OP_R; mem_ready = 1'b1; #1;
        checks++;
        if (outs !== e_fetch(1'b1, IM_I)) begin
            $display("FAIL rst_restart_fetch: got %h want %h", outs, e_fetch(1'b1, IM_I)); errors++;
        end
        @(negedge clk); #1;
        checks++;
        if (outs !== e_decode(IM_I)) begin
            $display("FAIL rst_restart_decode: got %h want %h", outs, e_decode(IM_I)); errors++;
        end
        @(negedge clk); #1;
        checks++;
        if (outs !== e_execr(IM_I)) begin
            $display("FAIL rst_restart_execr: got %h want %h", outs, e_execr(IM_I)); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype_fetch_stall();
        test_lw_wait();
        test_sw_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal_jalr();
        test_illegal();
        test_reset_in_memwrite();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
